// File: rtl/index_mask_builder.sv
// index_mask_builder
//   Sequential inverse of a lowest-set-bit encoder. Accepts a stream of bit
//   indices, decodes each to one-hot, ORs them into an accumulating mask and
//   presents the completed mask as one frame when the last index arrives.
//
// Parameters
//   MASKBITWIDTH   width of the assembled mask (>= 2)
//   INDEXBITWIDTH  index width, derived from MASKBITWIDTH; do not override
//
// Ports
//   clk, rst_n     single clock, synchronous active-low reset
//   idx_valid/idx_ready/idx_data/idx_null/idx_last   index token input
//   mask_valid/mask_ready/mask_data/mask_count       completed frame output
//   dup_err        frame set an index that was already set in that frame
//   range_err      frame carried an index >= MASKBITWIDTH (sets no bit)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
//   high. valid never depends on ready; once mask_valid is high it and the
//   frame data hold until accepted. idx_ready is a pure register output.
//
// Build option
//   INDEX_MASK_BUILDER_DBUF_EN: when defined, a hold buffer lets collection of
//   the next frame continue while a completed frame waits for acceptance.
//   Undefined (default): single accumulator, one idx_ready bubble per frame.
module index_mask_builder #(
  parameter int MASKBITWIDTH  = 16,
  parameter int INDEXBITWIDTH = $clog2(MASKBITWIDTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     idx_valid,
  output logic                     idx_ready,
  input  logic [INDEXBITWIDTH-1:0] idx_data,
  input  logic                     idx_null,
  input  logic                     idx_last,
  output logic                     mask_valid,
  input  logic                     mask_ready,
  output logic [MASKBITWIDTH-1:0]  mask_data,
  output logic [INDEXBITWIDTH:0]   mask_count,
  output logic                     dup_err,
  output logic                     range_err
);

  localparam int CW = INDEXBITWIDTH + 1;

  // COLLECT: no frame on the output. PRESENT: mask_valid high.
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  localparam logic [CW-1:0] MASK_LIM = CW'(MASKBITWIDTH);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic [0:0]              state;
  logic [MASKBITWIDTH-1:0] acc;
  logic [CW-1:0]           cnt;
  logic                    dup;
  logic                    rng;

  logic                    in_range;
  logic [MASKBITWIDTH-1:0] onehot;
  logic [MASKBITWIDTH-1:0] next_acc;
  logic [CW-1:0]           next_cnt;
  logic                    next_dup;
  logic                    next_rng;

  logic                    tok_acc;
  logic                    out_acc;

`ifdef INDEX_MASK_BUILDER_DBUF_EN
  // Second completed frame parked while the presented one is unaccepted.
  logic                    hold_valid;
  logic [MASKBITWIDTH-1:0] hold_data;
  logic [CW-1:0]           hold_count;
  logic                    hold_dup;
  logic                    hold_rng;

  assign idx_ready = ~hold_valid;
`else
  assign idx_ready = (state == COLLECT);
`endif

  assign mask_valid = (state == PRESENT);
  assign tok_acc    = idx_valid & idx_ready;
  assign out_acc    = mask_valid & mask_ready;

  // Effect of the current token on the frame being collected.
  always_comb begin
    in_range = ({1'b0, idx_data} < MASK_LIM);
    onehot   = '0;
    if (in_range) begin
      onehot[idx_data] = 1'b1;
    end
    next_acc = acc;
    next_cnt = cnt;
    next_dup = dup;
    next_rng = rng;
    if (!idx_null) begin
      if (in_range) begin
        next_acc = acc | onehot;
        if (cnt != CNT_MAX) begin
          next_cnt = cnt + CW'(1);
        end
        if ((acc & onehot) != '0) begin
          next_dup = 1'b1;
        end
      end else begin
        next_rng = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= COLLECT;
      acc        <= '0;
      cnt        <= '0;
      dup        <= 1'b0;
      rng        <= 1'b0;
      mask_data  <= '0;
      mask_count <= '0;
      dup_err    <= 1'b0;
      range_err  <= 1'b0;
`ifdef INDEX_MASK_BUILDER_DBUF_EN
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_count <= '0;
      hold_dup   <= 1'b0;
      hold_rng   <= 1'b0;
`endif
    end else begin
      // Accumulator: a last token hands its result off and restarts empty.
      if (tok_acc) begin
        if (idx_last) begin
          acc <= '0;
          cnt <= '0;
          dup <= 1'b0;
          rng <= 1'b0;
        end else begin
          acc <= next_acc;
          cnt <= next_cnt;
          dup <= next_dup;
          rng <= next_rng;
        end
      end

`ifdef INDEX_MASK_BUILDER_DBUF_EN
      if (tok_acc && idx_last && (state == COLLECT || out_acc)) begin
        // Output slot free now (or freed this cycle): present directly.
        mask_data  <= next_acc;
        mask_count <= next_cnt;
        dup_err    <= next_dup;
        range_err  <= next_rng;
        state      <= PRESENT;
      end else if (tok_acc && idx_last) begin
        // Output still occupied: park the frame and stall the input.
        hold_data  <= next_acc;
        hold_count <= next_cnt;
        hold_dup   <= next_dup;
        hold_rng   <= next_rng;
        hold_valid <= 1'b1;
      end else if (out_acc && hold_valid) begin
        mask_data  <= hold_data;
        mask_count <= hold_count;
        dup_err    <= hold_dup;
        range_err  <= hold_rng;
        hold_valid <= 1'b0;
      end else if (out_acc) begin
        state <= COLLECT;
      end
`else
      if (tok_acc && idx_last) begin
        mask_data  <= next_acc;
        mask_count <= next_cnt;
        dup_err    <= next_dup;
        range_err  <= next_rng;
        state      <= PRESENT;
      end else if (out_acc) begin
        state <= COLLECT;
      end
`endif
    end
  end

endmodule

// File: tb/tb_index_mask_builder.sv
module tb_index_mask_builder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 16-bit instance
  logic        a_idx_valid, a_idx_ready, a_idx_null, a_idx_last;
  logic [3:0]  a_idx_data;
  logic        a_mask_valid, a_mask_ready, a_dup_err, a_range_err;
  logic [15:0] a_mask_data;
  logic [4:0]  a_mask_count;

  // 10-bit instance (indices 10..15 are out of range)
  logic        b_idx_valid, b_idx_ready, b_idx_null, b_idx_last;
  logic [3:0]  b_idx_data;
  logic        b_mask_valid, b_mask_ready, b_dup_err, b_range_err;
  logic [9:0]  b_mask_data;
  logic [4:0]  b_mask_count;

  index_mask_builder #(.MASKBITWIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .idx_valid(a_idx_valid), .idx_ready(a_idx_ready), .idx_data(a_idx_data),
    .idx_null(a_idx_null), .idx_last(a_idx_last),
    .mask_valid(a_mask_valid), .mask_ready(a_mask_ready), .mask_data(a_mask_data),
    .mask_count(a_mask_count), .dup_err(a_dup_err), .range_err(a_range_err)
  );

  index_mask_builder #(.MASKBITWIDTH(10)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .idx_valid(b_idx_valid), .idx_ready(b_idx_ready), .idx_data(b_idx_data),
    .idx_null(b_idx_null), .idx_last(b_idx_last),
    .mask_valid(b_mask_valid), .mask_ready(b_mask_ready), .mask_data(b_mask_data),
    .mask_count(b_mask_count), .dup_err(b_dup_err), .range_err(b_range_err)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [3:0] d, input logic n, input logic l);
    int w = 0;
    while (!a_idx_ready && w < 10) begin
      tick();
      w++;
    end
    if (!a_idx_ready) chk("a_ready_timeout", {31'd0, a_idx_ready}, 32'd1);
    a_idx_valid = 1'b1;
    a_idx_data  = d;
    a_idx_null  = n;
    a_idx_last  = l;
    tick();
    a_idx_valid = 1'b0;
    a_idx_null  = 1'b0;
    a_idx_last  = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] d, input logic n, input logic l);
    int w = 0;
    while (!b_idx_ready && w < 10) begin
      tick();
      w++;
    end
    if (!b_idx_ready) chk("b_ready_timeout", {31'd0, b_idx_ready}, 32'd1);
    b_idx_valid = 1'b1;
    b_idx_data  = d;
    b_idx_null  = n;
    b_idx_last  = l;
    tick();
    b_idx_valid = 1'b0;
    b_idx_null  = 1'b0;
    b_idx_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_idx_valid = 0; a_idx_data = 0; a_idx_null = 0; a_idx_last = 0; a_mask_ready = 1;
    b_idx_valid = 0; b_idx_data = 0; b_idx_null = 0; b_idx_last = 0; b_mask_ready = 1;

    // Reset state
    tick();
    tick();
    chk("rst_mask_valid", a_mask_valid, 0);
    chk("rst_mask_data",  a_mask_data, 0);
    chk("rst_mask_count", a_mask_count, 0);
    chk("rst_dup_err",    a_dup_err, 0);
    chk("rst_range_err",  a_range_err, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_idx_ready",  a_idx_ready, 1);
    chk("rst_b_ready",    b_idx_ready, 1);

    // Tokens 3, 0, 15(last)
    send_a(4'd3, 0, 0);
    send_a(4'd0, 0, 0);
    send_a(4'd15, 0, 1);
    chk("f1_valid", a_mask_valid, 1);
    chk("f1_data",  a_mask_data, 32'h8009);
    chk("f1_count", a_mask_count, 3);
    chk("f1_dup",   a_dup_err, 0);
    chk("f1_range", a_range_err, 0);
    chk("f1_ready_low", a_idx_ready, 0);
    tick();
    chk("f1_ready_back", a_idx_ready, 1);
    chk("f1_valid_drop", a_mask_valid, 0);

    // Duplicate index
    send_a(4'd5, 0, 0);
    send_a(4'd5, 0, 1);
    chk("dup_data",  a_mask_data, 32'h0020);
    chk("dup_count", a_mask_count, 2);
    chk("dup_flag",  a_dup_err, 1);
    tick();
    send_a(4'd2, 0, 1);
    chk("dup_clr_data",  a_mask_data, 32'h0004);
    chk("dup_clr_flag",  a_dup_err, 0);
    chk("dup_clr_count", a_mask_count, 1);
    tick();

    // Empty frame
    send_a(4'd9, 1, 1);
    chk("empty_valid", a_mask_valid, 1);
    chk("empty_data",  a_mask_data, 0);
    chk("empty_count", a_mask_count, 0);
    tick();

    // Null non-last token has no effect
    send_a(4'd3, 0, 0);
    send_a(4'd8, 1, 0);
    send_a(4'd10, 0, 1);
    chk("null_mid_data",  a_mask_data, 32'h0408);
    chk("null_mid_count", a_mask_count, 2);
    tick();

    // Backpressure: mask_ready low for 4 cycles, input pulses ignored
    a_mask_ready = 1'b0;
    send_a(4'd4, 0, 0);
    send_a(4'd9, 0, 1);
    chk("bp_data0", a_mask_data, 32'h0210);
    for (int i = 0; i < 4; i++) begin
      a_idx_valid = 1'b1;
      a_idx_data  = 4'd1;
      a_idx_last  = 1'b1;
      tick();
      chk("bp_valid", a_mask_valid, 1);
      chk("bp_data",  a_mask_data, 32'h0210);
      chk("bp_count", a_mask_count, 2);
      chk("bp_ready", a_idx_ready, 0);
    end
    a_idx_valid = 1'b0;
    a_idx_last  = 1'b0;
    a_mask_ready = 1'b1;
    tick();
    chk("bp_release", a_mask_valid, 0);
    send_a(4'd6, 0, 1);
    chk("bp_after_data",  a_mask_data, 32'h0040);
    chk("bp_after_count", a_mask_count, 1);
    tick();

    // Count saturation: 35 in-range tokens
    for (int i = 0; i < 34; i++) send_a(4'(i), 0, 0);
    send_a(4'd0, 0, 1);
    chk("sat_data",  a_mask_data, 32'hffff);
    chk("sat_count", a_mask_count, 31);
    chk("sat_dup",   a_dup_err, 1);
    tick();

    // Out-of-range on the 10-bit instance
    send_b(4'd12, 0, 1);
    chk("rng_valid", b_mask_valid, 1);
    chk("rng_data",  b_mask_data, 0);
    chk("rng_flag",  b_range_err, 1);
    chk("rng_count", b_mask_count, 0);
    tick();
    send_b(4'd9, 0, 0);
    send_b(4'd10, 0, 0);
    send_b(4'd0, 0, 1);
    chk("rng2_data",  b_mask_data, 32'h201);
    chk("rng2_count", b_mask_count, 2);
    chk("rng2_flag",  b_range_err, 1);
    tick();
    send_b(4'd1, 0, 1);
    chk("rng3_flag", b_range_err, 0);
    chk("rng3_data", b_mask_data, 32'h002);
    tick();

    // Reset mid-frame discards the partial frame
    send_a(4'd1, 0, 0);
    send_a(4'd2, 0, 0);
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", a_mask_valid, 0);
    chk("midrst_count", a_mask_count, 0);
    rst_n = 1'b1;
    send_a(4'd7, 0, 1);
    chk("midrst_data",  a_mask_data, 32'h0080);
    chk("midrst_count2", a_mask_count, 1);
    tick();

`ifdef INDEX_MASK_BUILDER_DBUF_EN
    // Back-to-back single-token frames, one per cycle
    a_mask_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_idx_valid = 1'b1;
      a_idx_data  = 4'(i);
      a_idx_last  = 1'b1;
      tick();
      chk("dbuf_valid", a_mask_valid, 1);
      chk("dbuf_data",  a_mask_data, 32'd1 << i);
      chk("dbuf_ready", a_idx_ready, 1);
    end
    a_idx_valid = 1'b0;
    a_idx_last  = 1'b0;
    tick();
    chk("dbuf_drain", a_mask_valid, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/index_mask_builder.md
Name: index_mask_builder

Overview:
Sequential inverse of the lowest-set-bit encoder. It accepts a stream of bit indices over a valid/ready handshake and decodes each index to one-hot. It ORs the decoded bits into an accumulating mask and emits the completed mask as one frame when the last index arrives. It sits between encoder-driven request logic, such as arbiters and freelist allocators, and consumers that need a bit-vector view, such as grant or release vectors.

Parameters:
MASKBITWIDTH, 16, width of the assembled mask; any value >= 2.
INDEXBITWIDTH, $clog2(MASKBITWIDTH), index width; derived, do not override.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset; synchronous, active-low.
idx_valid  input  1  index token valid.
idx_ready  output  1  block can accept a token this cycle.
idx_data  input  INDEXBITWIDTH  bit index to set.
idx_null  input  1  token carries no index; idx_data is ignored, only idx_last is honoured.
idx_last  input  1  token closes the current frame.
mask_valid  output  1  completed mask available.
mask_ready  input  1  consumer accepts the mask.
mask_data  output  MASKBITWIDTH  completed mask.
mask_count  output  INDEXBITWIDTH+1  number of non-null in-range tokens in the frame; saturates at 2^(INDEXBITWIDTH+1)-1.
dup_err  output  1  frame contained an index already set earlier in the same frame.
range_err  output  1  frame contained idx_data >= MASKBITWIDTH; that token sets no bit.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: while rst_n=0 at a rising edge:
  - state becomes COLLECT.
  - accumulator, count and error flags clear.
  - mask_valid=0, mask_data=0, mask_count=0, dup_err=0, range_err=0.
  - idx_ready=1 from the first cycle after reset is released.
- Reset mid-frame or mid-present discards all partial or pending data. No output handshake completes for the discarded frame.
- Token accept: idx_valid & idx_ready.
- Output accept: mask_valid & mask_ready.
- State COLLECT:
  - idx_ready=1, mask_valid=0.
  - Accepted non-null in-range token: accumulator |= (1 << idx_data) and count++.
  - If that bit was already set, the frame dup flag sets.
  - Out-of-range token: range flag sets; accumulator and count are unchanged.
  - Null token: no change to accumulator or count.
  - Accepted token with idx_last=1 (null or not): the token's own effect is included, the result is latched into the output registers, and the next state is PRESENT.
- State PRESENT:
  - mask_valid=1, idx_ready=0.
  - mask_data, mask_count, dup_err and range_err are stable until output accept.
  - On output accept: accumulator, count and flags clear, and the next state is COLLECT.
- Latency: mask_valid rises the cycle after the last token is accepted.
- Minimum frame period (non-DBUF build): last token plus one PRESENT cycle, i.e. one idx_ready bubble per frame.
- Empty frame (a single null last token): mask_data=0, mask_count=0. This is legal and presented normally.
- A null token with idx_last=0 is legal and has no effect.
- idx_data, idx_null and idx_last are ignored when idx_valid=0.
- Inputs may change freely while idx_ready=0.
- mask_valid, once high, stays high until accepted; mask_ready may be high early.
- No combinational path from mask_ready to idx_ready in the non-DBUF build.

Optional Feature:
Macro: INDEX_MASK_BUILDER_DBUF_EN.
- Defined: a second accumulator allows collection to continue while a completed frame is held in PRESENT.
  - idx_ready=1 unless a second frame has completed while the first is still unaccepted.
  - In that case idx_ready=0 until output accept; the second frame is then presented the next cycle.
  - If output accept and a last-token accept occur in the same cycle, the new frame appears on mask_data the following cycle with mask_valid continuously high.
  - Sustains one frame per cycle for single-token frames.
- Undefined: single accumulator; behaviour exactly as described under Behaviour.

Test Plan:
- Reset, then MASKBITWIDTH=16, tokens 3, 0, 15(last) with mask_ready=1 -> one cycle after last: mask_valid=1, mask_data=16'h8009, mask_count=3, dup_err=0, range_err=0; idx_ready=0 for exactly one cycle.
- Tokens 5, 5(last) -> mask_data=16'h0020, mask_count=2, dup_err=1; next frame 2(last) -> mask_data=16'h0004, dup_err=0.
- Single null last token -> mask_data=0, mask_count=0, mask_valid=1; MASKBITWIDTH=10 with token 12(last) -> mask_data=0, range_err=1, mask_count=0.
- Frame complete, mask_ready held 0 for 4 cycles -> mask_valid and mask_data stable, idx_ready=0 throughout (non-DBUF); idx_valid pulses meanwhile have no effect.
- rst_n=0 for one cycle after tokens 1, 2 (no last), then token 7(last) -> mask_data=16'h0080, mask_count=1.
- DBUF build: back-to-back single-token last frames 0, 1, 2 with mask_ready=1 -> masks 16'h0001, 16'h0002, 16'h0004 on consecutive cycles, idx_ready never drops.
